dense_requant_writeback: RTL and testbench

Downstream stage of the dense-layer compute block. Consumes its 64 x 32-bit pre-activation accumulator vector once computation completes. Each active element is requantized to int8 (fixed-point multiply, rounding shift, zero-point add, optional ReLU, saturation). Results are written sequentially into tensor RAM as the next layer's input vector.

---
 rtl/dense_requant_writeback_pkg.sv | 32 +++
 rtl/dense_requant_writeback_requant_unit.sv | 92 +++++++++
 rtl/dense_requant_writeback.sv | 139 +++++++++++++
 tb/tb_dense_requant_writeback.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_requant_writeback_pkg.sv
// Shared types and constants for the dense-layer requantization writeback stage.
// Holds the control state encoding and the int8 saturation helper.
package sys_types;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } requant_state_t;

   localparam int MAX_OUT  = 64;
   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   // Clamp a wide signed value into [lo, INT8_MAX] and return the int8 bit pattern.
   function automatic logic [7:0] sat_int8(input logic signed [34:0] v,
                                           input logic signed [34:0] lo);
      logic signed [34:0] hi;
      logic        [7:0]  res;
      hi = 35'(INT8_MAX);
      if (v > hi) begin
         res = hi[7:0];
      end else if (v < lo) begin
         res = lo[7:0];
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/dense_requant_writeback_requant_unit.sv
// Three-stage requantization datapath: operand capture, Q31 multiply,
// rounding shift with zero-point add and int8 saturation. No back-pressure.
module requant_unit #(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic signed [31:0]  in_acc,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic signed [31:0]  quant_mult,
   input  logic [4:0]          quant_shift,
   input  logic signed [7:0]   zero_point,
   input  logic                relu_en,
   output logic                s1_valid,
   output logic                s2_valid,
   output logic                out_we,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [7:0]          out_din
);
   import sys_types::*;

   logic                s1_valid_reg;
   logic signed [31:0]  s1_acc_reg;
   logic [ADDR_W-1:0]   s1_addr_reg;

   logic                s2_valid_reg;
   logic signed [63:0]  s2_prod_reg;
   logic [ADDR_W-1:0]   s2_addr_reg;

   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [7:0]          din_reg;

   logic signed [63:0]  prod_next;
   logic [5:0]          rnd_pos;
   logic [5:0]          sh_amt;
   logic signed [64:0]  rnd_sum;
   logic signed [33:0]  r_val;
   logic signed [34:0]  zp_ext;
   logic signed [34:0]  v_val;
   logic signed [34:0]  lo_val;
   logic [7:0]          din_next;

   always_comb begin
      prod_next = $signed({{32{s1_acc_reg[31]}}, s1_acc_reg}) *
                  $signed({{32{quant_mult[31]}}, quant_mult});
   end

   // r stays 34 bits wide so the zero-point add cannot wrap before clamping.
   always_comb begin
      rnd_pos  = 6'd30 + {1'b0, quant_shift};
      sh_amt   = rnd_pos + 6'd1;
      rnd_sum  = $signed({s2_prod_reg[63], s2_prod_reg}) + (65'sd1 <<< rnd_pos);
      r_val    = 34'(rnd_sum >>> sh_amt);
      zp_ext   = $signed({{27{zero_point[7]}}, zero_point});
      v_val    = $signed({r_val[33], r_val}) + zp_ext;
      lo_val   = relu_en ? zp_ext : 35'(INT8_MIN);
      din_next = sat_int8(v_val, lo_val);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_acc_reg   <= '0;
         s1_addr_reg  <= '0;
         s2_valid_reg <= 1'b0;
         s2_prod_reg  <= '0;
         s2_addr_reg  <= '0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         din_reg      <= '0;
      end else begin
         s1_valid_reg <= in_valid;
         s1_acc_reg   <= in_acc;
         s1_addr_reg  <= in_addr;
         s2_valid_reg <= s1_valid_reg;
         s2_prod_reg  <= prod_next;
         s2_addr_reg  <= s1_addr_reg;
         we_reg       <= s2_valid_reg;
         addr_reg     <= s2_addr_reg;
         din_reg      <= din_next;
      end
   end

   assign s1_valid = s1_valid_reg;
   assign s2_valid = s2_valid_reg;
   assign out_we   = we_reg;
   assign out_addr = addr_reg;
   assign out_din  = din_reg;

endmodule

// File: rtl/dense_requant_writeback.sv
// Requantizes the dense-layer accumulator vector to int8 and writes it
// sequentially into tensor RAM; holds the control FSM and latched configuration.
module dense_requant_writeback #(
   parameter int MAX_OUT = 64,
   parameter int ADDR_W  = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [6:0]          output_size,
   input  logic signed [31:0]  acc_vector [0:MAX_OUT-1],
   input  logic signed [31:0]  quant_mult,
   input  logic [4:0]          quant_shift,
   input  logic signed [7:0]   out_zero_point,
   input  logic                relu_en,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic [ADDR_W-1:0]   tensor_ram_addr,
   output logic                tensor_ram_we,
   output logic [7:0]          tensor_ram_din,
   output logic                busy,
   output logic                done
);
   import sys_types::*;

   localparam int SEL_W = $clog2(MAX_OUT);

   requant_state_t      state_reg, state_next;
   logic [6:0]          idx_reg, idx_next;
   logic [6:0]          size_reg;
   logic [6:0]          size_clamped;
   logic signed [31:0]  mult_reg;
   logic [4:0]          shift_reg;
   logic signed [7:0]   zp_reg;
   logic                relu_reg;
   logic [ADDR_W-1:0]   base_reg;

   logic                accept;
   logic                issue;
   logic signed [31:0]  issue_acc;
   logic [ADDR_W-1:0]   issue_addr;
   logic                s1_valid;
   logic                s2_valid;

   always_comb begin
      size_clamped = (output_size > 7'(MAX_OUT)) ? 7'(MAX_OUT) : output_size;
      accept       = (state_reg == IDLE) && start;
   end

   // Leave DRAIN once only the output stage can still hold data, so done
   // lands in the cycle right after the final write.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      issue      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               idx_next   = '0;
               state_next = (size_clamped == 7'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            issue    = 1'b1;
            idx_next = idx_reg + 7'd1;
            if (idx_reg == size_reg - 7'd1) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!s1_valid && !s2_valid) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         size_reg  <= '0;
         mult_reg  <= '0;
         shift_reg <= '0;
         zp_reg    <= '0;
         relu_reg  <= 1'b0;
         base_reg  <= '0;
      end else if (accept) begin
         size_reg  <= size_clamped;
         mult_reg  <= quant_mult;
         shift_reg <= quant_shift;
         zp_reg    <= out_zero_point;
         relu_reg  <= relu_en;
         base_reg  <= base_addr;
      end
   end

   // Address arithmetic wraps modulo the RAM size.
   always_comb begin
      issue_acc  = acc_vector[idx_reg[SEL_W-1:0]];
      issue_addr = base_reg + ADDR_W'(idx_reg);
   end

   requant_unit #(
      .ADDR_W (ADDR_W)
   ) u_requant (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (issue),
      .in_acc      (issue_acc),
      .in_addr     (issue_addr),
      .quant_mult  (mult_reg),
      .quant_shift (shift_reg),
      .zero_point  (zp_reg),
      .relu_en     (relu_reg),
      .s1_valid    (s1_valid),
      .s2_valid    (s2_valid),
      .out_we      (tensor_ram_we),
      .out_addr    (tensor_ram_addr),
      .out_din     (tensor_ram_din)
   );

   assign busy = (state_reg == RUN) || (state_reg == DRAIN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_dense_requant_writeback.sv
// Directed bench for dense_requant_writeback: a reference requant model feeds a
// scoreboard of expected RAM writes, checked as the DUT emits them.
module tb_dense_requant_writeback;

   localparam int ADDR_W = 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start;
   logic [6:0]          output_size;
   logic signed [31:0]  acc_vector [0:63];
   logic signed [31:0]  quant_mult;
   logic [4:0]          quant_shift;
   logic signed [7:0]   out_zero_point;
   logic                relu_en;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W-1:0]   tensor_ram_addr;
   logic                tensor_ram_we;
   logic [7:0]          tensor_ram_din;
   logic                busy;
   logic                done;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   we_count = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dense_requant_writeback #(
      .MAX_OUT (64),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .output_size     (output_size),
      .acc_vector      (acc_vector),
      .quant_mult      (quant_mult),
      .quant_shift     (quant_shift),
      .out_zero_point  (out_zero_point),
      .relu_en         (relu_en),
      .base_addr       (base_addr),
      .tensor_ram_addr (tensor_ram_addr),
      .tensor_ram_we   (tensor_ram_we),
      .tensor_ram_din  (tensor_ram_din),
      .busy            (busy),
      .done            (done)
   );

   // Reference: round-half-up Q31 scaling, zero point, clamp to [lo,127].
   function automatic logic [7:0] model(int acc, int mult, int sh, int zp, bit relu);
      longint p;
      longint r;
      longint v;
      longint lo;
      p  = longint'(acc) * longint'(mult);
      r  = (p + (longint'(1) << (30 + sh))) >>> (31 + sh);
      v  = r + longint'(zp);
      lo = relu ? longint'(zp) : -128;
      if (v > 127) v = 127;
      else if (v < lo) v = lo;
      return v[7:0];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every write strobe must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1 && tensor_ram_we === 1'b1) begin
         we_count++;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed addr=%0h din=%0h expected no write",
                   tensor_ram_addr, tensor_ram_din);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("write addr=%02h din=%02h (exp addr=%02h din=%02h) t=%0d",
                     tensor_ram_addr, tensor_ram_din, e.addr, e.data, cyc);
            chk("wr_addr", 32'(tensor_ram_addr), 32'(e.addr));
            chk("wr_din", 32'(tensor_ram_din), 32'(e.data));
         end
      end
   end

   task automatic run_case(int size, int mult, int sh, int zp, bit relu, int base,
                           bit poke_start);
      int  eff;
      int  c0;
      bit  seen;
      exp_t e;
      @(negedge clk);
      eff = (size > 64) ? 64 : size;
      output_size    = 7'(size);
      quant_mult     = mult;
      quant_shift    = 5'(sh);
      out_zero_point = 8'(zp);
      relu_en        = relu;
      base_addr      = 8'(base);
      for (int i = 0; i < eff; i++) begin
         e.addr = 8'(base + i);
         e.data = model(acc_vector[i], mult, sh, zp, relu);
         sb.push_back(e);
      end
      we_count = 0;
      start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      if (eff > 0) chk("busy_in_run", 32'(busy), 32'd1);
      // Scramble live config; the run must keep using the latched values.
      quant_mult     = 32'h1357_9BDF;
      quant_shift    = 5'd9;
      out_zero_point = 8'sd55;
      relu_en        = ~relu;
      base_addr      = 8'hAA;
      output_size    = 7'd5;
      if (poke_start) begin
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_latency", 32'(cyc - c0), 32'((eff == 0) ? 1 : eff + 4));
      chk("we_count", 32'(we_count), 32'(eff));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      @(negedge clk);
      chk("done_single", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("no_restart", 32'(busy), 32'd0);
      $display("case size=%0d mult=%08h sh=%0d zp=%0d relu=%0d base=%02h writes=%0d",
               size, mult, sh, zp, relu, base, we_count);
   endtask

   initial begin
      reset_n        = 1'b0;
      start          = 1'b0;
      output_size    = '0;
      quant_mult     = '0;
      quant_shift    = '0;
      out_zero_point = '0;
      relu_en        = 1'b0;
      base_addr      = '0;
      for (int i = 0; i < 64; i++) acc_vector[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_we", 32'(tensor_ram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(tensor_ram_addr), 32'd0);
      chk("rst_din", 32'(tensor_ram_din), 32'd0);
      reset_n = 1'b1;

      acc_vector[0] = 100;
      acc_vector[1] = 3;
      run_case(2, 32'h4000_0000, 0, -10, 1'b0, 8'h10, 1'b0);

      acc_vector[0] = -3;
      acc_vector[1] = 1000;
      acc_vector[2] = -100;
      run_case(3, 32'h4000_0000, 0, 0, 1'b0, 8'h20, 1'b1);
      run_case(3, 32'h4000_0000, 0, -10, 1'b1, 8'h30, 1'b0);

      for (int i = 0; i < 64; i++) acc_vector[i] = i << 8;
      run_case(64, 32'h7FFF_FFFF, 4, 0, 1'b0, 8'hF0, 1'b1);

      run_case(0, 32'h4000_0000, 0, 0, 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 64; i++) acc_vector[i] = int'($urandom);
      run_case(70, int'($urandom), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 255)) - 128, 1'b1, int'($urandom_range(0, 255)), 1'b0);

      for (int i = 0; i < 64; i++) acc_vector[i] = int'($urandom_range(0, 200000)) - 100000;
      run_case(17, 32'h0100_0000, 2, 7, 1'b0, 8'h80, 1'b0);

      // Abort a long run with reset and confirm an immediate, silent stop.
      @(negedge clk);
      output_size    = 7'd64;
      quant_mult     = 32'h4000_0000;
      quant_shift    = 5'd0;
      out_zero_point = 8'sd0;
      relu_en        = 1'b0;
      base_addr      = 8'h00;
      for (int i = 0; i < 64; i++) begin
         exp_t e;
         e.addr = 8'(i);
         e.data = model(acc_vector[i], 32'h4000_0000, 0, 0, 1'b0);
         sb.push_back(e);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_abort_we", 32'(tensor_ram_we), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_we", 32'(tensor_ram_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_abort_done", 32'(done), 32'd0);
      end

      acc_vector[0] = 100;
      acc_vector[1] = 3;
      acc_vector[2] = -1000;
      acc_vector[3] = 77;
      acc_vector[4] = -5;
      run_case(5, 32'h4000_0000, 0, -10, 1'b0, 8'h40, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
